// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - M-mode trap entry/return sequencer and trap CSR subset (optional counter: TRAP_COUNT_EN)
module trap_controller #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      trapID,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [31:0]     faulting_inst_i,
    input  logic [XLEN-1:0] faulting_va_IMEM_i,
    input  logic [XLEN-1:0] faulting_va_DMEM_i,
    input  logic            mret_i,
    input  logic [11:0]     csr_addr_i,
    input  logic            csr_we_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o,
    output logic            mie_o
);

    localparam logic [4:0]  EXCEPT_DO_NOTHING = 5'h1F;
    localparam logic [11:0] ADDR_MSTATUS      = 12'h300;
    localparam logic [11:0] ADDR_MTVEC        = 12'h305;
    localparam logic [11:0] ADDR_MEPC         = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE       = 12'h342;
    localparam logic [11:0] ADDR_MTVAL        = 12'h343;
    localparam logic [11:0] ADDR_TRAP_COUNT   = 12'hBC0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTER  = 2'd1,
        S_RETURN = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic            mie;
    logic            mpie;
    logic [XLEN-1:0] mtval_next;
    logic            trap_take;
    logic            mret_take;
    logic            wr_mstatus;
    logic            wr_mtvec;
    logic            wr_mepc;
    logic            wr_mcause;
    logic            wr_mtval;

`ifdef TRAP_COUNT_EN
    logic [31:0]     trap_count;
    logic            wr_trap_count;
    assign wr_trap_count = csr_we_i && (csr_addr_i == ADDR_TRAP_COUNT);
`endif

    // Trap beats mret; both are only honoured from IDLE because the flush kills their sources.
    assign trap_take = (state == S_IDLE) && (trapID != EXCEPT_DO_NOTHING);
    assign mret_take = (state == S_IDLE) && !trap_take && mret_i;

    assign wr_mstatus = csr_we_i && (csr_addr_i == ADDR_MSTATUS);
    assign wr_mtvec   = csr_we_i && (csr_addr_i == ADDR_MTVEC);
    assign wr_mepc    = csr_we_i && (csr_addr_i == ADDR_MEPC);
    assign wr_mcause  = csr_we_i && (csr_addr_i == ADDR_MCAUSE);
    assign wr_mtval   = csr_we_i && (csr_addr_i == ADDR_MTVAL);

    assign mie_o = mie;

    // Select the trap value that accompanies each exception code.
    always_comb begin
        mtval_next = '0;
        case (trapID)
            5'd0:          mtval_next = trap_pc_i;
            5'd2:          mtval_next = XLEN'(faulting_inst_i);
            5'd12:         mtval_next = faulting_va_IMEM_i;
            5'd13, 5'd15:  mtval_next = faulting_va_DMEM_i;
            default:       mtval_next = '0;
        endcase
    end

    // Sequencer: one cycle in ENTER/RETURN, with a registered one-shot redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            busy_o        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trap_take) begin
                        state         <= S_ENTER;
                        redirect_o    <= 1'b1;
                        redirect_pc_o <= {mtvec[XLEN-1:2], 2'b00};
                        busy_o        <= 1'b1;
                    end else if (mret_take) begin
                        state         <= S_RETURN;
                        redirect_o    <= 1'b1;
                        redirect_pc_o <= mepc;
                        busy_o        <= 1'b1;
                    end else begin
                        redirect_o    <= 1'b0;
                        busy_o        <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    redirect_o <= 1'b0;
                    busy_o     <= 1'b0;
                end
            endcase
        end
    end

    // CSR storage: trap entry and mret override software writes to the registers they touch.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec  <= RESET_MTVEC;
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
            mie    <= 1'b0;
            mpie   <= 1'b0;
        end else begin
            if (wr_mtvec) begin
                mtvec <= {csr_wdata_i[XLEN-1:2], 2'b00};
            end
            if (trap_take) begin
                mepc   <= {trap_pc_i[XLEN-1:2], 2'b00};
                mcause <= {{(XLEN-5){1'b0}}, trapID};
                mtval  <= mtval_next;
                mpie   <= mie;
                mie    <= 1'b0;
            end else begin
                if (mret_take) begin
                    mie  <= mpie;
                    mpie <= 1'b1;
                end else if (wr_mstatus) begin
                    mie  <= csr_wdata_i[3];
                    mpie <= csr_wdata_i[7];
                end
                if (wr_mepc) begin
                    mepc <= {csr_wdata_i[XLEN-1:2], 2'b00};
                end
                if (wr_mcause) begin
                    mcause <= csr_wdata_i;
                end
                if (wr_mtval) begin
                    mtval <= csr_wdata_i;
                end
            end
        end
    end

`ifdef TRAP_COUNT_EN
    // Trap counter: software write wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_count <= '0;
        end else if (wr_trap_count) begin
            trap_count <= 32'(csr_wdata_i);
        end else if (trap_take) begin
            trap_count <= trap_count + 32'd1;
        end
    end
`endif

    // Read mux reflects pre-edge state; MPP is hardwired to machine mode.
    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            ADDR_MSTATUS: begin
                csr_rdata_o[3]     = mie;
                csr_rdata_o[7]     = mpie;
                csr_rdata_o[12:11] = 2'b11;
            end
            ADDR_MTVEC:  csr_rdata_o = {mtvec[XLEN-1:2], 2'b00};
            ADDR_MEPC:   csr_rdata_o = mepc;
            ADDR_MCAUSE: csr_rdata_o = mcause;
            ADDR_MTVAL:  csr_rdata_o = mtval;
`ifdef TRAP_COUNT_EN
            ADDR_TRAP_COUNT: csr_rdata_o = XLEN'(trap_count);
`endif
            default:     csr_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - randomized and directed bench for trap_controller
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  trapID = 5'h1F;
    logic [31:0] trap_pc_i = '0;
    logic [31:0] faulting_inst_i = '0;
    logic [31:0] faulting_va_IMEM_i = '0;
    logic [31:0] faulting_va_DMEM_i = '0;
    logic        mret_i = 1'b0;
    logic [11:0] csr_addr_i = '0;
    logic        csr_we_i = 1'b0;
    logic [31:0] csr_wdata_i = '0;
    logic [31:0] csr_rdata_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;
    logic        mie_o;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [31:0] m_mtvec = 32'h100, m_mepc = '0, m_mcause = '0, m_mtval = '0, m_rpc = '0, m_count = '0;
    logic        m_mie = 1'b0, m_mpie = 1'b0, m_busy = 1'b0, m_redirect = 1'b0;

    trap_controller #(.XLEN(32), .RESET_MTVEC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .trapID(trapID), .trap_pc_i(trap_pc_i),
        .faulting_inst_i(faulting_inst_i), .faulting_va_IMEM_i(faulting_va_IMEM_i),
        .faulting_va_DMEM_i(faulting_va_DMEM_i), .mret_i(mret_i),
        .csr_addr_i(csr_addr_i), .csr_we_i(csr_we_i), .csr_wdata_i(csr_wdata_i),
        .csr_rdata_o(csr_rdata_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .busy_o(busy_o), .mie_o(mie_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [11:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h305: v = m_mtvec;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
`ifdef TRAP_COUNT_EN
            12'hBC0: v = m_count;
`endif
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Advance the model by one clock edge from the current inputs, then step the DUT.
    task automatic tick();
        logic [31:0] n_mtvec, n_mepc, n_mcause, n_mtval, n_rpc, n_count;
        logic        n_mie, n_mpie, n_busy, n_redirect, wr;
        n_mtvec = m_mtvec; n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval;
        n_rpc = m_rpc; n_count = m_count; n_mie = m_mie; n_mpie = m_mpie;
        n_busy = 1'b0; n_redirect = 1'b0;
        wr = csr_we_i;
        if (rst) begin
            n_mtvec = 32'h100; n_mepc = 0; n_mcause = 0; n_mtval = 0; n_rpc = 0; n_count = 0;
            n_mie = 0; n_mpie = 0;
        end else if (!m_busy && trapID != 5'h1F) begin
            n_mepc = trap_pc_i & ~32'h3;
            n_mcause = 32'(trapID);
            case (trapID)
                5'd0:         n_mtval = trap_pc_i;
                5'd2:         n_mtval = faulting_inst_i;
                5'd12:        n_mtval = faulting_va_IMEM_i;
                5'd13, 5'd15: n_mtval = faulting_va_DMEM_i;
                default:      n_mtval = 0;
            endcase
            n_mpie = m_mie; n_mie = 0;
            n_busy = 1; n_redirect = 1; n_rpc = m_mtvec & ~32'h3;
            n_count = m_count + 1;
            if (wr && csr_addr_i == 12'h305) n_mtvec = csr_wdata_i & ~32'h3;
            if (wr && csr_addr_i == 12'hBC0) n_count = csr_wdata_i;
        end else begin
            if (!m_busy && mret_i) begin
                n_mie = m_mpie; n_mpie = 1;
                n_busy = 1; n_redirect = 1; n_rpc = m_mepc;
            end else if (wr && csr_addr_i == 12'h300) begin
                n_mie = csr_wdata_i[3]; n_mpie = csr_wdata_i[7];
            end
            if (wr && csr_addr_i == 12'h305) n_mtvec = csr_wdata_i & ~32'h3;
            if (wr && csr_addr_i == 12'h341) n_mepc = csr_wdata_i & ~32'h3;
            if (wr && csr_addr_i == 12'h342) n_mcause = csr_wdata_i;
            if (wr && csr_addr_i == 12'h343) n_mtval = csr_wdata_i;
            if (wr && csr_addr_i == 12'hBC0) n_count = csr_wdata_i;
        end
        @(posedge clk);
        #1;
        m_mtvec = n_mtvec; m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval;
        m_rpc = n_rpc; m_count = n_count; m_mie = n_mie; m_mpie = n_mpie;
        m_busy = n_busy; m_redirect = n_redirect;
    endtask

    task automatic test_reset();
        logic [11:0] a[5];
        logic [31:0] e[5];
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total += 4;
        if (redirect_o !== 1'b0) begin bad++; $display("FAIL reset_redirect: got %b expected 0", redirect_o); end
        if (redirect_pc_o !== 32'h0) begin bad++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        if (mie_o !== 1'b0) begin bad++; $display("FAIL reset_mie: got %b expected 0", mie_o); end
        a = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343};
        e = '{32'h1800, 32'h100, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            csr_addr_i = a[i]; #1;
            total++;
            if (csr_rdata_o !== e[i]) begin bad++; $display("FAIL reset_csr_%h: got %h expected %h", a[i], csr_rdata_o, e[i]); end
        end
    endtask

    task automatic test_illegal();
        logic [11:0] a[5];
        logic [31:0] e[5];
        csr_we_i = 1; csr_addr_i = 12'h305; csr_wdata_i = 32'h200; tick();
        csr_addr_i = 12'h300; csr_wdata_i = 32'h8; tick();
        csr_we_i = 0;
        trapID = 5'd2; trap_pc_i = 32'h1006; faulting_inst_i = 32'hFFFF_FFFF;
        tick();
        trapID = 5'h1F;
        total += 4;
        if (redirect_o !== 1'b1) begin bad++; $display("FAIL illegal_redirect: got %b expected 1", redirect_o); end
        if (redirect_pc_o !== 32'h200) begin bad++; $display("FAIL illegal_redirect_pc: got %h expected 200", redirect_pc_o); end
        if (busy_o !== 1'b1) begin bad++; $display("FAIL illegal_busy: got %b expected 1", busy_o); end
        if (mie_o !== 1'b0) begin bad++; $display("FAIL illegal_mie: got %b expected 0", mie_o); end
        a = '{12'h300, 12'h341, 12'h342, 12'h343, 12'h305};
        e = '{32'h1880, 32'h1004, 32'h2, 32'hFFFF_FFFF, 32'h200};
        for (int i = 0; i < 5; i++) begin
            csr_addr_i = a[i]; #1;
            total++;
            if (csr_rdata_o !== e[i]) begin bad++; $display("FAIL illegal_csr_%h: got %h expected %h", a[i], csr_rdata_o, e[i]); end
        end
        tick();
        total++;
        if (redirect_o !== 1'b0) begin bad++; $display("FAIL illegal_redirect_drop: got %b expected 0", redirect_o); end
    endtask

    task automatic test_return();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        csr_addr_i = 12'h300; #1;
        total += 4;
        if (redirect_o !== 1'b1) begin bad++; $display("FAIL mret_redirect: got %b expected 1", redirect_o); end
        if (redirect_pc_o !== 32'h1004) begin bad++; $display("FAIL mret_redirect_pc: got %h expected 1004", redirect_pc_o); end
        if (mie_o !== 1'b1) begin bad++; $display("FAIL mret_mie: got %b expected 1", mie_o); end
        if (csr_rdata_o !== 32'h1888) begin bad++; $display("FAIL mret_mstatus: got %h expected 1888", csr_rdata_o); end
        tick();
        total++;
        if (redirect_o !== 1'b0) begin bad++; $display("FAIL mret_redirect_drop: got %b expected 0", redirect_o); end
    endtask

    task automatic test_load_pf();
        trapID = 5'd13; faulting_va_DMEM_i = 32'hDEAD_B000; trap_pc_i = 32'h2000;
        tick();
        trapID = 5'h1F;
        csr_addr_i = 12'h342; #1;
        total++;
        if (csr_rdata_o !== 32'd13) begin bad++; $display("FAIL lpf_mcause: got %h expected d", csr_rdata_o); end
        csr_addr_i = 12'h343; #1;
        total++;
        if (csr_rdata_o !== 32'hDEAD_B000) begin bad++; $display("FAIL lpf_mtval: got %h expected deadb000", csr_rdata_o); end
        tick();
    endtask

    task automatic test_simultaneous();
        trapID = 5'd12; mret_i = 1'b1; faulting_va_IMEM_i = 32'h4000;
        tick();
        trapID = 5'd0; trap_pc_i = 32'h5000;
        total += 2;
        if (redirect_o !== 1'b1) begin bad++; $display("FAIL simul_redirect: got %b expected 1", redirect_o); end
        if (redirect_pc_o !== 32'h200) begin bad++; $display("FAIL simul_redirect_pc: got %h expected 200", redirect_pc_o); end
        tick();
        trapID = 5'h1F; mret_i = 1'b0;
        csr_addr_i = 12'h342; #1;
        total += 3;
        if (csr_rdata_o !== 32'd12) begin bad++; $display("FAIL simul_mcause: got %h expected c", csr_rdata_o); end
        if (redirect_o !== 1'b0) begin bad++; $display("FAIL simul_no_mret_redirect: got %b expected 0", redirect_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL simul_busy: got %b expected 0", busy_o); end
        csr_addr_i = 12'h343; #1;
        total++;
        if (csr_rdata_o !== 32'h4000) begin bad++; $display("FAIL simul_mtval: got %h expected 4000", csr_rdata_o); end
        tick();
        total++;
        if (redirect_o !== 1'b0) begin bad++; $display("FAIL simul_late_redirect: got %b expected 0", redirect_o); end
    endtask

    task automatic test_csr_vs_trap();
        csr_we_i = 1; csr_addr_i = 12'h341; csr_wdata_i = 32'h8000;
        trapID = 5'd0; trap_pc_i = 32'h3000;
        tick();
        csr_we_i = 0; trapID = 5'h1F;
        csr_addr_i = 12'h341; #1;
        total++;
        if (csr_rdata_o !== 32'h3000) begin bad++; $display("FAIL cvt_mepc: got %h expected 3000", csr_rdata_o); end
        csr_addr_i = 12'h343; #1;
        total++;
        if (csr_rdata_o !== 32'h3000) begin bad++; $display("FAIL cvt_mtval: got %h expected 3000", csr_rdata_o); end
        tick();
        csr_we_i = 1; csr_addr_i = 12'h305; csr_wdata_i = 32'h123;
        #1;
        total++;
        if (csr_rdata_o !== 32'h200) begin bad++; $display("FAIL cvt_no_writethrough: got %h expected 200", csr_rdata_o); end
        tick();
        csr_we_i = 0; #1;
        total++;
        if (csr_rdata_o !== 32'h120) begin bad++; $display("FAIL cvt_mtvec_align: got %h expected 120", csr_rdata_o); end
        csr_we_i = 1; csr_addr_i = 12'h7FF; csr_wdata_i = 32'hA5A5_A5A5;
        tick();
        csr_we_i = 0; #1;
        total++;
        if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL cvt_unmapped: got %h expected 0", csr_rdata_o); end
    endtask

    task automatic test_reset_mid();
        trapID = 5'd2; trap_pc_i = 32'h6000; faulting_inst_i = 32'h1234_5678;
        tick();
        trapID = 5'h1F;
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL rmid_busy_before: got %b expected 1", busy_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total += 2;
        if (redirect_o !== 1'b0) begin bad++; $display("FAIL rmid_redirect: got %b expected 0", redirect_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b expected 0", busy_o); end
        csr_addr_i = 12'h305; #1;
        total++;
        if (csr_rdata_o !== 32'h100) begin bad++; $display("FAIL rmid_mtvec: got %h expected 100", csr_rdata_o); end
        csr_addr_i = 12'h341; #1;
        total++;
        if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL rmid_mepc: got %h expected 0", csr_rdata_o); end
    endtask

    task automatic test_counter();
        csr_we_i = 1; csr_addr_i = 12'hBC0; csr_wdata_i = 32'hFFFF_FFFF;
        tick();
        csr_we_i = 0;
        trapID = 5'd15; faulting_va_DMEM_i = 32'h7000;
        tick();
        trapID = 5'h1F;
        csr_addr_i = 12'hBC0; #1;
        total++;
        if (csr_rdata_o !== 32'h0) begin bad++; $display("FAIL counter_wrap: got %h expected 0", csr_rdata_o); end
        tick();
`ifdef TRAP_COUNT_EN
        trapID = 5'd2;
        tick();
        trapID = 5'h1F;
        tick();
        csr_addr_i = 12'hBC0; #1;
        total++;
        if (csr_rdata_o !== 32'h1) begin bad++; $display("FAIL counter_inc: got %h expected 1", csr_rdata_o); end
`endif
    endtask

    task automatic test_random();
        logic [4:0]  codes[8];
        logic [11:0] addrs[8];
        logic        prev_redirect;
        codes = '{5'd0, 5'd2, 5'd12, 5'd13, 5'd15, 5'd1, 5'd3, 5'd7};
        addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'hBC0, 12'h7FF, 12'h000};
        prev_redirect = redirect_o;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            trapID = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 7)] : 5'h1F;
            mret_i = ($urandom_range(0, 4) == 0);
            trap_pc_i = $urandom;
            faulting_inst_i = $urandom;
            faulting_va_IMEM_i = $urandom;
            faulting_va_DMEM_i = $urandom;
            csr_addr_i = addrs[$urandom_range(0, 7)];
            csr_we_i = ($urandom_range(0, 3) == 0);
            csr_wdata_i = $urandom;
            #1;
            total += 5;
            if (redirect_o !== m_redirect) begin bad++; $display("FAIL rnd_redirect[%0d]: got %b expected %b", n, redirect_o, m_redirect); end
            if (busy_o !== m_busy) begin bad++; $display("FAIL rnd_busy[%0d]: got %b expected %b", n, busy_o, m_busy); end
            if (mie_o !== m_mie) begin bad++; $display("FAIL rnd_mie[%0d]: got %b expected %b", n, mie_o, m_mie); end
            if (csr_rdata_o !== model_read(csr_addr_i)) begin
                bad++; $display("FAIL rnd_csr_%h[%0d]: got %h expected %h", csr_addr_i, n, csr_rdata_o, model_read(csr_addr_i));
            end
            if (prev_redirect && redirect_o) begin bad++; $display("FAIL rnd_double_redirect[%0d]: got 1 expected 0", n); end
            if (m_redirect) begin
                total++;
                if (redirect_pc_o !== m_rpc) begin bad++; $display("FAIL rnd_redirect_pc[%0d]: got %h expected %h", n, redirect_pc_o, m_rpc); end
            end
            prev_redirect = redirect_o;
            tick();
        end
        rst = 0; trapID = 5'h1F; mret_i = 0; csr_we_i = 0;
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_return();
        test_load_pf();
        test_simultaneous();
        test_csr_vs_trap();
        test_reset_mid();
        test_counter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Consumer end of the exception protocol: takes the trap ID, faulting instruction and faulting VA raised by the hazard/exception logic at the MEM boundary.
- Performs M-mode trap entry: latches mepc/mcause/mtval, updates mstatus, redirects fetch to mtvec.
- Performs the matching mret return sequence.
- Owns the trap CSR subset and exposes a CSR read/write port to the CSR instruction datapath.

Parameters:
- XLEN, 32, data/address width.
- RESET_MTVEC, 32'h0000_0100, mtvec value after reset.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- trapID  input  5  exception code; 5'h1F = EXCEPT_DO_NOTHING; otherwise equals mcause code (0 misaligned PC, 2 illegal, 12 inst PF, 13 load PF, 15 store PF).
- trap_pc_i  input  XLEN  PC of the MEM-stage instruction.
- faulting_inst_i  input  32  instruction word for illegal-instruction traps.
- faulting_va_IMEM_i  input  XLEN  fetch VA for instruction page faults.
- faulting_va_DMEM_i  input  XLEN  data VA for load/store page faults.
- mret_i  input  1  MEM-stage mret retiring.
- csr_addr_i  input  12  CSR address.
- csr_we_i  input  1  CSR write strobe.
- csr_wdata_i  input  XLEN  CSR write data.
- csr_rdata_o  output  XLEN  combinational read data.
- redirect_o  output  1  one-cycle fetch redirect; drives csr_branch_signal, which flushes the pipeline.
- redirect_pc_o  output  XLEN  redirect target.
- busy_o  output  1  high in ENTER/RETURN.
- mie_o  output  1  mstatus.MIE.

Behaviour:
- Reset values:
  - state IDLE; redirect_o=0; redirect_pc_o=0; busy_o=0.
  - mtvec=RESET_MTVEC; mepc=mcause=mtval=0.
  - mstatus: MIE=0, MPIE=0, MPP=2'b11.
- States:
  - IDLE: if trapID!=5'h1F go to ENTER; else if mret_i go to RETURN; else stay.
  - ENTER: always returns to IDLE next cycle.
  - RETURN: always returns to IDLE next cycle.
- Trap entry latency: trap sampled at edge E.
  - At E: mepc={trap_pc_i[XLEN-1:2],2'b00}, mcause={27'b0,trapID}, mtval set per mtval rule, MPIE<=MIE, MIE<=0, MPP<=2'b11.
  - Cycle after E: redirect_o=1, redirect_pc_o={mtvec[XLEN-1:2],2'b00}, busy_o=1.
- mtval rule:
  - Code 0: trap_pc_i.
  - Code 2: faulting_inst_i.
  - Code 12: faulting_va_IMEM_i.
  - Codes 13/15: faulting_va_DMEM_i.
  - Any other code: 0.
- mret: sampled at edge E.
  - At E: MIE<=MPIE, MPIE<=1, MPP<=2'b11.
  - Cycle after E: redirect_o=1, redirect_pc_o=mepc.
- Priority and masking:
  - Trap and mret together in IDLE: trap wins, mret dropped.
  - In ENTER/RETURN, trapID and mret_i are ignored; the flush removes their sources.
- CSR map:
  - 0x300 mstatus: MIE bit3, MPIE bit7, MPP bits12:11 read 2'b11; all other bits read 0 and are write-ignored.
  - 0x305 mtvec: bits1:0 read 0.
  - 0x341 mepc: bits1:0 forced 0.
  - 0x342 mcause.
  - 0x343 mtval.
  - Unmapped addresses read 0; writes to them are dropped.
- CSR write vs. trap: a CSR write in the same cycle as trap entry loses to trap entry for mepc/mcause/mtval/mstatus; a write to mtvec in that cycle is still taken. The same rule applies to mstatus on mret.
- csr_rdata_o reflects register state before the current edge; there is no write-through.
- Reset mid-ENTER/RETURN: next cycle is IDLE, redirect_o=0, all CSRs at reset values.
- redirect_o is never high for two consecutive cycles.

Optional Feature:
- Macro TRAP_COUNT_EN.
- When defined:
  - Adds a 32-bit trap counter at CSR 0xBC0.
  - The counter increments on each IDLE->ENTER transition and wraps from 32'hFFFF_FFFF to 0.
  - Reset value is 0; the counter is writable via the CSR port.
  - A write on the same cycle as an increment takes the written value.
- When undefined: 0xBC0 behaves as unmapped (reads 0), and no counter flops exist.

Test Plan:
- Illegal instruction:
  - Stimulus: mtvec=0x200, MIE=1; trapID=2, trap_pc_i=0x1006, faulting_inst_i=0xFFFF_FFFF for one cycle.
  - Response: next cycle redirect_o=1, redirect_pc_o=0x200; mepc reads 0x1004, mcause=2, mtval=0xFFFF_FFFF, MIE=0, MPIE=1; redirect_o=0 the cycle after.
- Load page fault:
  - Stimulus: trapID=13, faulting_va_DMEM_i=0xDEAD_B000.
  - Response: mcause=13, mtval=0xDEAD_B000.
- Return:
  - Stimulus: after the illegal-instruction trap, mret_i=1.
  - Response: next cycle redirect_pc_o=0x1004, MIE=1, MPIE=1.
- Simultaneous trap and mret:
  - Stimulus: trapID=12, mret_i=1, faulting_va_IMEM_i=0x4000.
  - Response: ENTER taken, mcause=12, mtval=0x4000, no mret redirect follows.
  - Also: trapID=0 presented while busy_o=1 is ignored (mcause unchanged).
- CSR write vs. trap:
  - Stimulus: write mepc=0x8000 in the same cycle as trapID=0 with trap_pc_i=0x3000.
  - Response: mepc=0x3000, mtval=0x3000.
  - Also: write mtvec=0x123 -> reads 0x120; read of 0x7FF -> 0.
- Reset and counter:
  - Stimulus: assert rst during ENTER.
  - Response: next cycle redirect_o=0, mtvec=RESET_MTVEC.
  - With TRAP_COUNT_EN: write 0xFFFF_FFFF to 0xBC0 then take one trap -> reads 0.
